// File: rtl/encoder_8x3_queue_if.sv
// Handshake bundle for the 8-request priority encoder queue: request load in, code/valid out, ready back.
interface encoder_8x3_queue_if;
   logic [7:0] D;
   logic       load;
   logic       ready;
   logic       x;
   logic       y;
   logic       z;
   logic       valid;
   logic [3:0] count;
   logic       ovf;

   modport master (
      output D, load, ready,
      input  x, y, z, valid, count, ovf
   );

   modport slave (
      input  D, load, ready,
      output x, y, z, valid, count, ovf
   );
endinterface

// File: rtl/encoder_8x3_queue.sv
// Priority encoder queue: merges loaded requests, emits the highest pending index; ready=0 holds code and set.
// Load edge -> valid next cycle; optional sticky lost-request flag under ENCODER_OVF_FLAG_EN.
module encoder_8x3_queue (
   input  logic                clk,
   input  logic                rst_n,
   encoder_8x3_queue_if.slave  bus
);

   typedef enum logic {IDLE, SERVE} state_t;

   state_t     state;
   logic [7:0] pend;
   logic [7:0] pend_clr;
   logic [7:0] pend_nxt;
   logic [7:0] acc_mask;
   logic [2:0] code;
   logic [3:0] count_q;
   logic       accept;

   function automatic logic [2:0] top_index(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   function automatic logic [3:0] pop_count(input logic [7:0] v);
      logic [3:0] cnt;
      cnt = 4'd0;
      for (int i = 0; i < 8; i++) begin
         cnt = cnt + {3'b000, v[i]};
      end
      return cnt;
   endfunction

   assign accept = (state == SERVE) && bus.ready;

   // Accept clears first, then load ORs in, so a reloaded accepted bit survives.
   always_comb begin
      acc_mask = 8'h00;
      if (accept) acc_mask[code] = 1'b1;
      pend_clr = pend & ~acc_mask;
      pend_nxt = bus.load ? (pend_clr | bus.D) : pend_clr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pend    <= 8'h00;
         code    <= 3'd0;
         count_q <= 4'd0;
      end else begin
         pend    <= pend_nxt;
         code    <= top_index(pend_nxt);
         count_q <= pop_count(pend_nxt);
         state   <= (pend_nxt == 8'h00) ? IDLE : SERVE;
      end
   end

   assign bus.valid = (state == SERVE);
   assign bus.x     = code[2];
   assign bus.y     = code[1];
   assign bus.z     = code[0];
   assign bus.count = count_q;

`ifdef ENCODER_OVF_FLAG_EN
   logic ovf_q;

   // A request is lost when it lands on a bit still pending and not leaving this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (bus.load && ((bus.D & pend & ~acc_mask) != 8'h00)) begin
         ovf_q <= 1'b1;
      end
   end

   assign bus.ovf = ovf_q;
`else
   assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_encoder_8x3_queue.sv
// Randomized and directed bench for encoder_8x3_queue against a set-of-requests reference model.
module tb_encoder_8x3_queue;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   encoder_8x3_queue_if bus ();

   encoder_8x3_queue dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: which request numbers are outstanding, plus the lost flag.
   bit pend_m [8];
   bit ovf_m;

   function automatic int mdl_count();
      int n;
      n = 0;
      for (int i = 0; i < 8; i++) n += pend_m[i];
      return n;
   endfunction

   function automatic int mdl_code();
      for (int i = 7; i >= 0; i--) begin
         if (pend_m[i]) return i;
      end
      return 0;
   endfunction

   function automatic void mdl_reset();
      for (int i = 0; i < 8; i++) pend_m[i] = 1'b0;
      ovf_m = 1'b0;
   endfunction

   function automatic void mdl_edge(input bit ld, input logic [7:0] d, input bit rdy);
      int taken;
      taken = -1;
      if (mdl_count() > 0 && rdy) taken = mdl_code();
      if (ld) begin
         for (int i = 0; i < 8; i++) begin
            if (d[i] && pend_m[i] && i != taken) ovf_m = 1'b1;
         end
      end
      if (taken >= 0) pend_m[taken] = 1'b0;
      if (ld) begin
         for (int i = 0; i < 8; i++) begin
            if (d[i]) pend_m[i] = 1'b1;
         end
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] dut_code();
      return {bus.x, bus.y, bus.z};
   endfunction

   task automatic compare_all(input string tag);
      bit ovf_exp;
`ifdef ENCODER_OVF_FLAG_EN
      ovf_exp = ovf_m;
`else
      ovf_exp = 1'b0;
`endif
      check({tag, "_valid"}, 32'(bus.valid), 32'(mdl_count() > 0));
      check({tag, "_code"},  32'(dut_code()), 32'(mdl_code()));
      check({tag, "_count"}, 32'(bus.count), 32'(mdl_count()));
      check({tag, "_ovf"},   32'(bus.ovf), 32'(ovf_exp));
   endtask

   // Drive after a falling edge, let the rising edge act, compare at the next falling edge.
   task automatic step(input bit ld, input logic [7:0] d, input bit rdy, input string tag);
      bus.load  = ld;
      bus.D     = d;
      bus.ready = rdy;
      @(posedge clk);
      mdl_edge(ld, d, rdy);
      @(negedge clk);
      compare_all(tag);
   endtask

   // Reset asserted mid-cycle must clear outputs before any clock edge.
   task automatic mid_reset(input string tag);
      #2;
      rst_n = 1'b0;
      mdl_reset();
      #1;
      check({tag, "_rst_valid"}, 32'(bus.valid), 32'd0);
      check({tag, "_rst_count"}, 32'(bus.count), 32'd0);
      check({tag, "_rst_code"},  32'(dut_code()), 32'd0);
      check({tag, "_rst_ovf"},   32'(bus.ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      bus.load  = 1'b0;
      bus.D     = 8'h00;
      bus.ready = 1'b0;
      mdl_reset();
      repeat (2) @(negedge clk);
      compare_all("reset");
      rst_n = 1'b1;

      // Two requests, consumer stalled, then drained in priority order.
      step(1'b1, 8'h24, 1'b0, "ld24");
      check("ld24_code_k", 32'(dut_code()), 32'd5);
      check("ld24_cnt_k",  32'(bus.count), 32'd2);
      step(1'b0, 8'h00, 1'b0, "hold");
      step(1'b0, 8'h00, 1'b1, "acc5");
      check("acc5_code_k", 32'(dut_code()), 32'd2);
      step(1'b0, 8'h00, 1'b1, "acc2");
      check("acc2_valid_k", 32'(bus.valid), 32'd0);
      step(1'b0, 8'h00, 1'b1, "idle_rdy");
      step(1'b1, 8'h00, 1'b0, "ld_zero");

      // Preemption by a higher request.
      step(1'b1, 8'h04, 1'b0, "ld04");
      step(1'b1, 8'h80, 1'b0, "pre80");
      check("pre80_code_k", 32'(dut_code()), 32'd7);
      step(1'b0, 8'h00, 1'b1, "acc7");
      check("acc7_code_k", 32'(dut_code()), 32'd2);
      step(1'b0, 8'h00, 1'b1, "acc2b");

      // Accept and reload of the same bit on one edge.
      step(1'b1, 8'h08, 1'b0, "ld08");
      step(1'b1, 8'h08, 1'b1, "same08");
      check("same08_valid_k", 32'(bus.valid), 32'd1);
      check("same08_ovf_k",   32'(bus.ovf), 32'd0);
      step(1'b0, 8'h00, 1'b1, "acc3");

      // Reload of a stalled pending bit.
      step(1'b1, 8'h01, 1'b0, "ld01");
      step(1'b1, 8'h01, 1'b0, "lost01");
      step(1'b0, 8'h00, 1'b1, "acc0");
      step(1'b0, 8'h00, 1'b0, "ovf_hold");
      mid_reset("ovfclr");

      // Full load drained one per cycle, reset part way.
      step(1'b1, 8'hFF, 1'b1, "ldff");
      for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 1'b1, "drain");
      mid_reset("drain");
      step(1'b1, 8'h10, 1'b0, "postrst");

      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 99) == 0) begin
            mid_reset("rnd");
         end else begin
            step(($urandom_range(0, 2) == 0), 8'($urandom), $urandom_range(0, 1) == 1, "rnd");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
